// File: rtl/mux_cfg_pkg.sv
// mux_cfg_pkg: shared op encodings, FSM states and clog2 helper for the mux config writer.
package mux_cfg_pkg;
    localparam logic [1:0] OP_SET_SEL = 2'b00;
    localparam logic [1:0] OP_ENABLE  = 2'b01;
    localparam logic [1:0] OP_DISABLE = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    typedef enum logic [2:0] {IDLE, ARG, EXEC, GUARD_OFF, APPLY, GUARD_ON, REEN} state_t;

    // Never returns less than 1 so derived vector widths stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/mux_guard_timer.sv
// mux_guard_timer: load/count/done counter that measures one break-before-make guard window.
module mux_guard_timer
    import mux_cfg_pkg::*;
#(
    parameter int GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int CW = clog2(GUARD_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holds at terminal count instead of wrapping.
    always_comb begin
        done  = cnt_q == CW'(GUARD_CYCLES - 1);
        cnt_d = load ? '0 : (en && !done) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/mux_cfg_writer.sv
// mux_cfg_writer: 2-byte command writer for the GPIO crossbar mux selectors and enables,
// with break-before-make guard windows when an enabled output is reselected.
module mux_cfg_writer
    import mux_cfg_pkg::*;
#(
    parameter int INPUT_COUNT  = 4,
    parameter int OUTPUT_COUNT = 4,
    parameter int GUARD_CYCLES = 2,
    localparam int SEL_W = clog2(INPUT_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    output logic [OUTPUT_COUNT*SEL_W-1:0] selectors,
    output logic [OUTPUT_COUNT-1:0]       enabled_out,
    output logic                          busy,
    output logic                          err
);
    localparam int KW = clog2(OUTPUT_COUNT);

    state_t                        state_q, state_d;
    logic [1:0]                    op_q, op_d;
    logic [5:0]                    k_q, k_d;
    logic [SEL_W-1:0]              arg_q, arg_d;
    logic [OUTPUT_COUNT*SEL_W-1:0] sel_q, sel_d;
    logic [OUTPUT_COUNT-1:0]       en_q, en_d;
    logic                          busy_q, busy_d, err_q, err_d, ready_q, ready_d;
    logic                          hs, tmr_load, tmr_en, tmr_done;
    logic [KW-1:0]                 idx;

    mux_guard_timer #(.GUARD_CYCLES(GUARD_CYCLES)) u_timer (
        .clk (clk),
        .rst (rst),
        .load(tmr_load),
        .en  (tmr_en),
        .done(tmr_done)
    );

    // err is registered at the argument handshake so it is high exactly while in EXEC.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        arg_d   = arg_q;
        sel_d   = sel_q;
        en_d    = en_q;
        err_d   = 1'b0;
        hs      = cmd_valid && ready_q;
        idx     = k_q[KW-1:0];
        case (state_q)
            IDLE: if (hs) begin
                op_d    = cmd_data[7:6];
                k_d     = cmd_data[5:0];
                state_d = ARG;
            end
            ARG: if (hs) begin
                arg_d   = cmd_data[SEL_W-1:0];
                err_d   = op_q == OP_RSVD || 32'(k_q) >= OUTPUT_COUNT ||
                          (op_q == OP_SET_SEL && 32'(cmd_data) >= INPUT_COUNT);
                state_d = EXEC;
            end
            EXEC: begin
                state_d = IDLE;
                if (!err_q) begin
                    if (op_q == OP_ENABLE) en_d[idx] = 1'b1;
                    else if (op_q == OP_DISABLE) en_d[idx] = 1'b0;
                    else if (!en_q[idx]) sel_d[idx*SEL_W +: SEL_W] = arg_q;
                    else if (sel_q[idx*SEL_W +: SEL_W] != arg_q) begin
                        en_d[idx] = 1'b0;
                        state_d   = GUARD_OFF;
                    end
                end
            end
            GUARD_OFF: if (tmr_done) state_d = APPLY;
            APPLY: begin
                sel_d[idx*SEL_W +: SEL_W] = arg_q;
                state_d = GUARD_ON;
            end
            GUARD_ON: if (tmr_done) state_d = REEN;
            REEN: begin
                en_d[idx] = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tmr_load = (state_q == EXEC && state_d == GUARD_OFF) || state_q == APPLY;
        tmr_en   = state_q == GUARD_OFF || state_q == GUARD_ON;
        busy_d   = !(state_d inside {IDLE, ARG});
        ready_d  = !busy_d;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            k_q     <= '0;
            arg_q   <= '0;
            sel_q   <= '1;
            en_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            arg_q   <= arg_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end

    assign selectors   = sel_q;
    assign enabled_out = en_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign cmd_ready   = ready_q;
endmodule

// File: tb/tb_mux_cfg_writer.sv
// tb_mux_cfg_writer: directed vector table, guard timing and reset sequences, then random
// commands checked against an array-based model of the mux configuration.
module tb_mux_cfg_writer;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cmd_data = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy, err;
    logic [7:0] selectors;
    logic [3:0] enabled_out;

    int tests_run = 0;
    int failed = 0;

    int         m_sel [4];
    bit         m_en  [4];
    int         bc, ec;
    bit         rbad;
    logic [7:0] tr_sel [64];
    logic [3:0] tr_en  [64];

    typedef struct {
        logic [7:0] b0, b1;
        logic [7:0] sel;
        logic [3:0] en;
        int         busy_cycles;
        int         errs;
    } vec_t;
    vec_t vecs [10];

    mux_cfg_writer #(.INPUT_COUNT(4), .OUTPUT_COUNT(4), .GUARD_CYCLES(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .selectors  (selectors),
        .enabled_out(enabled_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 100) begin
            tick();
            t++;
        end
        if (!cmd_ready) chk("handshake_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    // Sends both bytes, then traces outputs once per cycle from edge N until busy drops.
    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1);
        int i;
        send_byte(b0);
        send_byte(b1);
        bc = 0;
        ec = 0;
        rbad = 0;
        i = 0;
        while (busy && i < 63) begin
            tr_sel[i] = selectors;
            tr_en[i]  = enabled_out;
            bc++;
            if (err) ec++;
            if (cmd_ready) rbad = 1;
            tick();
            i++;
        end
        tr_sel[i] = selectors;
        tr_en[i]  = enabled_out;
        if (err) ec++;
    endtask

    function automatic logic [7:0] m_sel_vec();
        logic [7:0] v;
        for (int k = 0; k < 4; k++) v[k*2 +: 2] = 2'(m_sel[k]);
        return v;
    endfunction

    function automatic logic [3:0] m_en_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_en[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_sel[k] = 3;
            m_en[k]  = 0;
        end
    endtask

    // Applies one command to the model; returns expected busy cycles and err pulse count.
    task automatic model_cmd(input int op, input int k, input int arg, output int eb, output int ee);
        eb = 1;
        ee = 0;
        if (op == 3 || k >= 4 || (op == 0 && arg >= 4)) ee = 1;
        else if (op == 1) m_en[k] = 1;
        else if (op == 2) m_en[k] = 0;
        else begin
            if (m_en[k] && m_sel[k] != arg) eb = 2 * G + 3;
            m_sel[k] = arg;
        end
    endtask

    initial begin
        int eb, ee, op, k, arg;
        vecs[0] = '{8'h40, 8'h00, 8'hFF, 4'b0001, 1, 0};
        vecs[1] = '{8'h41, 8'h00, 8'hFF, 4'b0011, 1, 0};
        vecs[2] = '{8'h00, 8'h02, 8'hFE, 4'b0011, 7, 0};
        vecs[3] = '{8'h02, 8'h01, 8'hDE, 4'b0011, 1, 0};
        vecs[4] = '{8'h05, 8'h00, 8'hDE, 4'b0011, 1, 1};
        vecs[5] = '{8'hC0, 8'h00, 8'hDE, 4'b0011, 1, 1};
        vecs[6] = '{8'h00, 8'h07, 8'hDE, 4'b0011, 1, 1};
        vecs[7] = '{8'h00, 8'h02, 8'hDE, 4'b0011, 1, 0};
        vecs[8] = '{8'h81, 8'h00, 8'hDE, 4'b0001, 1, 0};
        vecs[9] = '{8'h42, 8'hAA, 8'hDE, 4'b0101, 1, 0};

        repeat (2) tick();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_sel", selectors, 8'hFF);
        chk("rst_en", enabled_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1);

        for (int v = 0; v < 10; v++) begin
            run_cmd(vecs[v].b0, vecs[v].b1);
            chk($sformatf("vec%0d_sel", v), selectors, vecs[v].sel);
            chk($sformatf("vec%0d_en", v), enabled_out, vecs[v].en);
            chk($sformatf("vec%0d_busy", v), bc, vecs[v].busy_cycles);
            chk($sformatf("vec%0d_err", v), ec, vecs[v].errs);
            chk($sformatf("vec%0d_ready_low", v), rbad, 0);
        end

        run_cmd(8'h00, 8'h01);
        chk("bbm_en_N", tr_en[0][0], 1);
        for (int i = 1; i < 7; i++) chk($sformatf("bbm_en_off_N%0d", i), tr_en[i][0], 0);
        chk("bbm_en_N7", tr_en[7][0], 1);
        chk("bbm_sel_N3", tr_sel[3][1:0], 2);
        chk("bbm_sel_N4", tr_sel[4][1:0], 1);
        chk("bbm_others", {tr_sel[5][7:2], tr_en[5][3:1]}, {6'b110111, 3'b010});
        chk("bbm_busy", bc, 7);

        send_byte(8'h00);
        send_byte(8'h03);
        repeat (3) tick();
        chk("mid_guard_off", enabled_out[0], 0);
        rst = 1'b1;
        #1;
        chk("midrst_sel", selectors, 8'hFF);
        chk("midrst_en", enabled_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        run_cmd(8'h43, 8'h00);
        chk("after_rst_en", enabled_out, 4'b1000);
        chk("after_rst_sel", selectors, 8'hFF);
        model_reset();
        m_en[3] = 1;

        for (int n = 0; n < 60; n++) begin
            op  = int'($urandom_range(0, 3));
            k   = int'($urandom_range(0, 5));
            arg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
            model_cmd(op, k, arg, eb, ee);
            repeat ($urandom_range(0, 2)) tick();
            send_byte({2'(op), 6'(k)});
            repeat ($urandom_range(0, 3)) tick();
            run_cmd_tail(8'(arg));
            chk($sformatf("rnd%0d_sel", n), selectors, m_sel_vec());
            chk($sformatf("rnd%0d_en", n), enabled_out, m_en_vec());
            chk($sformatf("rnd%0d_busy", n), bc, eb);
            chk($sformatf("rnd%0d_err", n), ec, ee);
            chk($sformatf("rnd%0d_ready_low", n), rbad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    // Second half of a command after an arbitrary gap in ARG.
    task automatic run_cmd_tail(input logic [7:0] b1);
        int i;
        send_byte(b1);
        bc = 0;
        ec = 0;
        rbad = 0;
        i = 0;
        while (busy && i < 63) begin
            bc++;
            if (err) ec++;
            if (cmd_ready) rbad = 1;
            tick();
            i++;
        end
        if (err) ec++;
    endtask
endmodule
